// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types, window defaults and window check for the RAM port arbiter
// Purpose: response-owner encoding, default RAM window, unsigned window test.
// Ports: none (package).
package ram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_I     = 2'd1,
        OWN_D     = 2'd2,
        OWN_D_ERR = 2'd3
    } owner_e;

    localparam logic [31:0] RAM_BASE_DEF = 32'h0000_2000;
    localparam logic [31:0] RAM_SIZE_DEF = 32'h0000_0800;

    // Upper bound is formed in 33 bits so a window ending at 2^32 cannot wrap.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        logic [32:0] limit;
        limit = {1'b0, base} + {1'b0, size};
        return (addr >= base) && ({1'b0, addr} < limit);
    endfunction

endpackage

// File: rtl/ram_arb_starve_ctr.sv
// rtl/ram_arb_starve_ctr.sv - saturating fetch-starvation counter
// Purpose: counts consecutive cycles the I-port loses arbitration.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   inc_i        I-request lost to a D-grant this cycle
//   clr_i        I-port granted or not requesting (wins over inc_i)
//   at_max_o     count has reached MAX
module ram_arb_starve_ctr #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam logic [3:0] MAX_C = 4'(MAX);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (inc_i && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == MAX_C);

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - single-port RAM arbiter between fetch (I) and load/store (D) ports
// Purpose: one grant per cycle, D priority with bounded I starvation, routes the
//          1-cycle RAM read data back to the owning port, flags out-of-window accesses.
// Optional feature macro: RAM_ARB_PERF_EN adds perf_conflicts / perf_forced counters.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   i_req/i_addr               fetch request (read only)
//   i_gnt/i_rvalid/i_rdata     fetch grant and response
//   d_req/d_we/d_be/d_addr/d_wdata   load/store request
//   d_gnt/d_rvalid/d_rdata/d_err     load/store grant and response
//   mem_rd/mem_wr/mem_be/mem_addr_o/mem_wdata_o/mem_data_i   RAM macro port
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter logic [31:0] RAM_BASE   = RAM_BASE_DEF,
    parameter logic [31:0] RAM_SIZE   = RAM_SIZE_DEF,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
`ifdef RAM_ARB_PERF_EN
    output logic [31:0] perf_conflicts,
    output logic [31:0] perf_forced,
`endif
    input  logic [31:0] mem_data_i
);

    owner_e      owner_q;
    owner_e      owner_d;
    logic        i_zero_q;   // outstanding I response was out of window: return 0
    logic        i_zero_d;
    logic        at_max;
    logic        any_gnt;
    logic        sel_inw;
    logic [31:0] sel_addr;

    ram_arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst),
        .inc_i    (i_req & d_gnt),
        .clr_i    (i_gnt | ~i_req),
        .at_max_o (at_max)
    );

    // Grants are gated by reset so nothing reaches the RAM while rst is low.
    assign i_gnt   = rst & i_req & (~d_req | at_max);
    assign d_gnt   = rst & d_req & ~i_gnt;
    assign any_gnt = i_gnt | d_gnt;

    assign sel_addr = i_gnt ? i_addr : d_addr;
    assign sel_inw  = in_window(sel_addr, RAM_BASE, RAM_SIZE);

    always_comb begin
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_be      = 4'h0;
        mem_wdata_o = 32'h0;
        mem_addr_o  = 32'h0;
        owner_d     = OWN_NONE;
        i_zero_d    = 1'b0;
        if (any_gnt) begin
            mem_addr_o = sel_addr - RAM_BASE;
        end
        if (i_gnt) begin
            mem_rd   = sel_inw;
            owner_d  = OWN_I;
            i_zero_d = ~sel_inw;
        end else if (d_gnt) begin
            if (!sel_inw) begin
                owner_d = OWN_D_ERR;
            end else if (d_we) begin
                mem_wr      = 1'b1;
                mem_be      = d_be;
                mem_wdata_o = d_wdata;
            end else begin
                mem_rd  = 1'b1;
                owner_d = OWN_D;
            end
        end
    end

    // Response owner FSM; a new grant may overlap the previous response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q  <= OWN_NONE;
            i_zero_q <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            i_zero_q <= i_zero_d;
        end
    end

    assign i_rvalid = (owner_q == OWN_I);
    assign i_rdata  = (i_rvalid && !i_zero_q) ? mem_data_i : 32'h0;
    assign d_rvalid = (owner_q == OWN_D);
    assign d_rdata  = d_rvalid ? mem_data_i : 32'h0;
    assign d_err    = (owner_q == OWN_D_ERR);

`ifdef RAM_ARB_PERF_EN
    logic [31:0] conflicts_q;
    logic [31:0] forced_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflicts_q <= 32'h0;
            forced_q    <= 32'h0;
        end else begin
            if (i_req && d_req) begin
                conflicts_q <= conflicts_q + 32'h1;
            end
            // An I-grant while D is also requesting can only come from starvation.
            if (i_gnt && d_req) begin
                forced_q <= forced_q + 32'h1;
            end
        end
    end

    assign perf_conflicts = conflicts_q;
    assign perf_forced    = forced_q;
`endif

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port instruction/data RAM window (0x0000_2000–0x0000_27FF) between two requesters: the fetch side (I-port, read-only) and the load/store unit (D-port, read/write).
- Grants one access per cycle, routes the 1-cycle synchronous RAM read data back to the owning port, and bounds fetch starvation.
- Sits between the CPU-side memory controllers and the RAM macro.

Parameters:
- RAM_BASE, 32'h0000_2000, byte address of RAM window start; subtracted from the granted address.
- RAM_SIZE, 32'h0000_0800, window size in bytes; addresses at or above RAM_BASE+RAM_SIZE are out of window.
- STARVE_MAX, 4, maximum consecutive cycles an I-request may lose to the D-port before a forced I-grant; range 1–15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held with i_addr stable until i_gnt.
- i_addr  in  32  fetch byte address.
- i_gnt  out  1  fetch granted this cycle.
- i_rvalid  out  1  i_rdata valid; exactly 1 cycle after i_gnt.
- i_rdata  out  32  fetch data.
- d_req  in  1  load/store request; held with d_addr/d_we/d_be/d_wdata stable until d_gnt.
- d_we  in  1  1 = write.
- d_be  in  4  byte enables for writes.
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_gnt  out  1  data request granted this cycle.
- d_rvalid  out  1  d_rdata valid; 1 cycle after a read grant only.
- d_rdata  out  32  load data.
- d_err  out  1  1-cycle pulse, 1 cycle after a grant whose address was out of window.
- mem_rd  out  1  RAM read strobe.
- mem_wr  out  1  RAM write strobe.
- mem_be  out  4  RAM byte enables.
- mem_addr_o  out  32  granted address minus RAM_BASE.
- mem_wdata_o  out  32  write data to RAM.
- mem_data_i  in  32  RAM read data; valid 1 cycle after mem_rd.

Behaviour:
- Reset (rst low, async): owner_r = NONE, starve_cnt = 0. All grant, valid, err and strobe outputs are 0; rdata outputs are 0.
- Grant logic is combinational from req and starve_cnt:
  - D wins by default.
  - I wins when only i_req is high, or when starve_cnt == STARVE_MAX and both requests are high.
  - At most one of i_gnt/d_gnt is high in any cycle.
- Granted access drives the memory port in the same cycle:
  - mem_addr_o = addr - RAM_BASE.
  - In-window read: mem_rd = 1. In-window D write: mem_wr = 1, mem_be = d_be, mem_wdata_o = d_wdata.
  - Out-of-window access: no strobe; d_err or i_rvalid with data 0 next cycle; d_err fires for D-port only, and the I-port returns data 0.
- Response FSM, owner_r ∈ {NONE, I, D, D_ERR}, registered each cycle from the grant:
  - I-grant → I.
  - D read → D.
  - D out-of-window → D_ERR.
  - D write or no grant → NONE.
- Response routing (combinational from owner_r):
  - I → i_rvalid = 1, i_rdata = mem_data_i.
  - D → d_rvalid = 1, d_rdata = mem_data_i.
  - D_ERR → d_err = 1.
  - Non-owner rdata is 0.
- Back-to-back grants allowed: new grant in the same cycle as the previous response, giving full throughput.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when i_req is high and d_gnt is high.
  - Clears on i_gnt or when i_req is low.
- Write completes at d_gnt; no response.
- Reset mid-access: the outstanding response is dropped and no rvalid follows.
- Window check is unsigned: RAM_BASE <= addr < RAM_BASE+RAM_SIZE. The address at RAM_BASE+RAM_SIZE-4 is in window; RAM_BASE+RAM_SIZE is out.

Optional Feature:
- RAM_ARB_PERF_EN defined:
  - Adds 32-bit outputs perf_conflicts (cycles with i_req and d_req both high) and perf_forced (forced I-grants).
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent; arbitration is identical.

Decomposition:
- Package ram_arb_pkg holds:
  - owner_e enum {OWN_NONE, OWN_I, OWN_D, OWN_D_ERR}.
  - RAM_BASE/RAM_SIZE defaults.
  - Function in_window(addr).
- One sub-module, ram_arb_starve_ctr: saturating counter with inc/clr/at_max.

Test Plan:
- I-only read 0x2004, mem_data_i = 0xDEADBEEF at next cycle → i_gnt cycle 0, mem_addr_o = 0x4, i_rvalid/i_rdata = 0xDEADBEEF cycle 1; d_rvalid = 0.
- Both requests held continuously, STARVE_MAX = 4 → d_gnt 4 cycles, i_gnt on cycle 5, counter clears, pattern repeats.
- D write 0x27FC be = 4'b0011 wdata 0x12345678 → mem_wr = 1, mem_addr_o = 0x7FC, mem_be = 0011; no d_rvalid next cycle.
- D read 0x2800 → no mem_rd, d_err pulse 1 cycle later; I read 0x1FFC → i_rvalid with 0.
- Alternating D read / I read every cycle → rvalid alternates correctly with no bubbles; rdata routed to the matching port.
- Assert rst low the cycle after an I-grant → i_rvalid stays 0, all outputs 0 during reset; traffic resumes normally after release.
